// File: rtl/conv_y_wr_seq.sv
// rtl/conv_y_wr_seq.sv - memY write-side sequencer for convolution results
module conv_y_wr_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              clr,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [ADDR_W-1:0] memY_addr,
    output logic [DATA_W-1:0] memY_data,
    output logic              memY_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_q;
    logic              xfer;

    assign res_ready = (state == WRITE) && !clr;
    assign xfer      = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            memY_addr <= '0;
            memY_data <= '0;
            memY_we   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            // Abort: already-issued writes stay in memY, address/data hold.
            state   <= IDLE;
            cnt     <= '0;
            memY_we <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    memY_we <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            len_q <= len;
                            cnt   <= '0;
                            state <= WRITE;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    memY_we <= xfer;
                    if (xfer) begin
                        memY_addr <= cnt;
                        memY_data <= res_data;
                        cnt       <= cnt + ONE;
                        // done lands in the same cycle as the final write.
                        if (cnt == len_q - ONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    memY_we <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    memY_we <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_y_wr_seq.sv
// tb/tb_conv_y_wr_seq.sv - directed self-checking bench for conv_y_wr_seq
module tb_conv_y_wr_seq;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] len;
    logic              clr;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] memY_addr;
    logic [DATA_W-1:0] memY_data;
    logic              memY_we;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    conv_y_wr_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .clr       (clr),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .memY_addr (memY_addr),
        .memY_data (memY_data),
        .memY_we   (memY_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One datapath cycle: present a sample, check ready, clock, check registered outputs.
    task automatic cyc(input string tag, input logic v, input logic [31:0] d,
                       input logic exp_rdy, input logic exp_we, input logic [31:0] exp_addr,
                       input logic exp_done, input logic exp_busy);
        res_valid = v;
        res_data  = d;
        #1;
        chk({tag, ".ready"}, {31'd0, res_ready}, {31'd0, exp_rdy});
        tick();
        chk({tag, ".we"},   {31'd0, memY_we}, {31'd0, exp_we});
        chk({tag, ".done"}, {31'd0, done},    {31'd0, exp_done});
        chk({tag, ".busy"}, {31'd0, busy},    {31'd0, exp_busy});
        if (exp_we) begin
            chk({tag, ".addr"}, {26'd0, memY_addr}, exp_addr);
            chk({tag, ".data"}, memY_data, d);
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; clr = 1'b0; res_data = '0; res_valid = 1'b0;
        tick();
        tick();
        chk("rst.addr", {26'd0, memY_addr}, 32'd0);
        chk("rst.data", memY_data, 32'd0);
        chk("rst.we",   {31'd0, memY_we}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.ready", {31'd0, res_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // len=4, continuous valid
        pulse_start(6'd4);
        chk("t1.busy_start", {31'd0, busy}, 32'd1);
        cyc("t1.s0", 1'b1, 32'h11, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        cyc("t1.s1", 1'b1, 32'h22, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        cyc("t1.s2", 1'b1, 32'h33, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1);
        cyc("t1.s3", 1'b1, 32'h44, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1);
        cyc("t1.after", 1'b1, 32'h55, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t1.hold_addr", {26'd0, memY_addr}, 32'd3);
        chk("t1.hold_data", memY_data, 32'h44);
        res_valid = 1'b0;
        tick();

        // len=3, valid pattern 1,0,0,1,0,1
        pulse_start(6'd3);
        cyc("t2.c0", 1'b1, 32'hA1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        cyc("t2.c1", 1'b0, 32'hFF, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("t2.c2", 1'b0, 32'hFE, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("t2.c3", 1'b1, 32'hA2, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        cyc("t2.c4", 1'b0, 32'hFD, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("t2.c5", 1'b1, 32'hA3, 1'b1, 1'b1, 32'd2, 1'b1, 1'b1);
        cyc("t2.after", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // len=0: straight to DONE, no writes
        res_valid = 1'b1;
        start = 1'b1;
        len = 6'd0;
        #1;
        chk("t3.ready_idle", {31'd0, res_ready}, 32'd0);
        tick();
        start = 1'b0;
        chk("t3.done", {31'd0, done}, 32'd1);
        chk("t3.busy", {31'd0, busy}, 32'd1);
        chk("t3.we",   {31'd0, memY_we}, 32'd0);
        chk("t3.ready_done", {31'd0, res_ready}, 32'd0);
        tick();
        chk("t3.done_off", {31'd0, done}, 32'd0);
        chk("t3.busy_off", {31'd0, busy}, 32'd0);
        chk("t3.we_off",   {31'd0, memY_we}, 32'd0);
        res_valid = 1'b0;

        // len=5 aborted by clr after 2 transfers
        pulse_start(6'd5);
        cyc("t4.s0", 1'b1, 32'hB0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        cyc("t4.s1", 1'b1, 32'hB1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        clr = 1'b1;
        cyc("t4.clr", 1'b1, 32'hB2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        clr = 1'b0;
        cyc("t4.idle", 1'b1, 32'hB3, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t4.hold_addr", {26'd0, memY_addr}, 32'd1);
        res_valid = 1'b0;
        // clr beats start in IDLE
        clr = 1'b1;
        pulse_start(6'd2);
        clr = 1'b0;
        chk("t4.clr_start_busy", {31'd0, busy}, 32'd0);
        pulse_start(6'd2);
        cyc("t4.r0", 1'b1, 32'hC0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        cyc("t4.r1", 1'b1, 32'hC1, 1'b1, 1'b1, 32'd1, 1'b1, 1'b1);
        cyc("t4.after", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // len=4 with a second start (len=9) during WRITE
        pulse_start(6'd4);
        cyc("t5.s0", 1'b1, 32'hD0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        start = 1'b1;
        len = 6'd9;
        cyc("t5.s1", 1'b1, 32'hD1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        start = 1'b0;
        cyc("t5.s2", 1'b1, 32'hD2, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1);
        cyc("t5.s3", 1'b1, 32'hD3, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1);
        cyc("t5.after", 1'b1, 32'hD4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5.hold_addr", {26'd0, memY_addr}, 32'd3);
        res_valid = 1'b0;

        // len=6 aborted by rst after 3 transfers
        pulse_start(6'd6);
        cyc("t6.s0", 1'b1, 32'hE0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        cyc("t6.s1", 1'b1, 32'hE1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        cyc("t6.s2", 1'b1, 32'hE2, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.rst_addr", {26'd0, memY_addr}, 32'd0);
        chk("t6.rst_data", memY_data, 32'd0);
        chk("t6.rst_we",   {31'd0, memY_we}, 32'd0);
        chk("t6.rst_done", {31'd0, done}, 32'd0);
        chk("t6.rst_busy", {31'd0, busy}, 32'd0);
        #1;
        chk("t6.rst_ready", {31'd0, res_ready}, 32'd0);
        res_valid = 1'b0;
        tick();

        // len=63, maximum run
        pulse_start(6'd63);
        for (int i = 0; i < 63; i++) begin
            cyc("t7.s", 1'b1, 32'h1000 + 32'(i) * 3, 1'b1, 1'b1, 32'(i), (i == 62), 1'b1);
        end
        cyc("t7.after", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t7.hold_addr", {26'd0, memY_addr}, 32'd62);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
